ysyx_24100029_icache: RTL and testbench

Direct-mapped, read-only instruction cache between the IFU's AXI4 read channels and the system AXI4 bus. It serves hits in one cycle from internal storage and refills whole lines with one INCR burst on a miss. It honours a `fence_i` flush request from the execute stage. The IFU side uses the same AR/R subset the IFU drives; write channels are not routed through this block.

---
 rtl/ysyx_24100029_icache_pkg.sv | 17 +
 rtl/ysyx_24100029_icache_array.sv | 55 +++++
 rtl/ysyx_24100029_icache.sv | 195 +++++++++++++++++++
 tb/tb_ysyx_24100029_icache.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100029_icache_pkg.sv
// Shared types and AXI encodings for the instruction cache.
package ysyx_24100029_icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [2:0] SIZE4  = 3'b010;

endpackage

// File: rtl/ysyx_24100029_icache_array.sv
// Valid/tag/data flop storage: combinational lookup read, one-word refill write, line validate, flush-all.
// Only valid bits are reset; tags and data hold whatever was last written.
module ysyx_24100029_icache_array
    import ysyx_24100029_icache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int WSEL_W     = $clog2(LINE_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WSEL_W-1:0] rd_wsel,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_word,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WSEL_W-1:0] wr_wsel,
    input  logic [31:0]       wr_data,
    input  logic              set_en,
    input  logic [TAG_W-1:0]  set_tag
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            data_q[wr_idx][wr_wsel] <= wr_data;
        end
        if (set_en) begin
            tag_q[wr_idx] <= set_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_wsel];

endmodule

// File: rtl/ysyx_24100029_icache.sv
// Direct-mapped read-only I-cache: hit answers 2 cycles after AR, miss refills the line with one INCR burst.
// s_rvalid holds until s_rready; one fetch in flight. ICACHE_PERF_EN adds hit_cnt/miss_cnt outputs.
module ysyx_24100029_icache
    import ysyx_24100029_icache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fence_i,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int OFF    = WSEL_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF - IDX_W;

    state_t             state;
    logic [31:2]        addr_q;
    logic [WSEL_W-1:0]  cnt;
    logic               err_q;
    logic               fence_pend;
    logic               arready_q;

    logic [IDX_W-1:0]   q_idx;
    logic [TAG_W-1:0]   q_tag;
    logic [WSEL_W-1:0]  q_wsel;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [31:0]        rd_word;
    logic               hit;
    logic               ar_hs;
    logic               flush;
    logic               beat;
    logic               beat_err;
    logic               set_en;
    logic               unused_ok;

    assign q_idx    = addr_q[OFF+IDX_W-1:OFF];
    assign q_tag    = addr_q[31:OFF+IDX_W];
    assign q_wsel   = addr_q[OFF-1:2];
    assign hit      = rd_valid && (rd_tag == q_tag);
    assign ar_hs    = s_arvalid && s_arready;
    assign flush    = (state == IDLE) && !ar_hs && (fence_i || fence_pend);
    assign beat     = (state == REFILL) && m_rvalid;
    assign beat_err = err_q || (m_rresp != OKAY);
    assign set_en   = beat && m_rlast && !beat_err;

    // Ready is gated by reset so it reads 0 in reset and 1 right after release.
    assign s_arready = arready_q && !reset;
    assign s_rlast   = s_rvalid;
    assign m_arid    = 4'd0;
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = SIZE4;
    assign m_arburst = INCR;
    assign unused_ok = ^s_araddr[1:0];

    ysyx_24100029_icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .rd_idx   (q_idx),
        .rd_wsel  (q_wsel),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_word  (rd_word),
        .wr_en    (beat),
        .wr_idx   (q_idx),
        .wr_wsel  (cnt),
        .wr_data  (m_rdata),
        .set_en   (set_en),
        .set_tag  (q_tag)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            arready_q  <= 1'b1;
            s_rvalid   <= 1'b0;
            s_rdata    <= '0;
            s_rresp    <= OKAY;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_rready   <= 1'b0;
            addr_q     <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            fence_pend <= 1'b0;
        end else begin
            if (state != IDLE && fence_i) begin
                fence_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        addr_q    <= s_araddr[31:2];
                        arready_q <= 1'b0;
                        state     <= LOOKUP;
                        // A fence racing an accepted fetch is ordered after it.
                        if (fence_i) fence_pend <= 1'b1;
                    end else begin
                        fence_pend <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        s_rdata  <= rd_word;
                        s_rresp  <= OKAY;
                        s_rvalid <= 1'b1;
                        state    <= RESP;
                    end else begin
                        m_arvalid <= 1'b1;
                        m_araddr  <= {addr_q[31:OFF], {OFF{1'b0}}};
                        state     <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        cnt       <= '0;
                        err_q     <= 1'b0;
                        state     <= REFILL;
                    end
                end
                REFILL: begin
                    if (m_rvalid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == q_wsel) s_rdata <= m_rdata;
                        if (m_rresp != OKAY) err_q <= 1'b1;
                        if (m_rlast) begin
                            m_rready <= 1'b0;
                            s_rvalid <= 1'b1;
                            s_rresp  <= beat_err ? SLVERR : OKAY;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (s_rready) begin
                        s_rvalid  <= 1'b0;
                        // A pending flush takes the first IDLE cycle with ready low.
                        arready_q <= !(fence_pend || fence_i);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24100029_icache.sv
// Directed bench for the I-cache: drives IFU fetches and acts as the refill bus slave.
module tb_ysyx_24100029_icache;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fence_i = 1'b0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_araddr = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rlast = 1'b0;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    ysyx_24100029_icache dut (
        .clock     (clock),
        .reset     (reset),
        .fence_i   (fence_i),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arid    (m_arid),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_arready"}, 32'(s_arready), 32'd0);
        check({tag, " s_rvalid"},  32'(s_rvalid),  32'd0);
        check({tag, " s_rdata"},   s_rdata,        32'd0);
        check({tag, " s_rresp"},   32'(s_rresp),   32'd0);
        check({tag, " m_arvalid"}, 32'(m_arvalid), 32'd0);
        check({tag, " m_rready"},  32'(m_rready),  32'd0);
        check({tag, " m_araddr"},  m_araddr,       32'd0);
    endtask

    // evt_kind: 0 none, 1 fence_i pulse with beat evt_beat, 2 reset before beat evt_beat.
    task automatic fetch(input string tag, input logic [31:0] addr, input bit exp_miss,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input int err_beat, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int hold,
                         input int evt_kind, input int evt_beat);
        logic [31:0] words [4];
        int          n;
        bit          miss;
        words = '{w0, w1, w2, w3};
        s_arvalid = 1'b1;
        s_araddr  = addr;
        n = 0;
        while (!s_arready && n < 20) begin
            tick;
            n++;
        end
        check({tag, " arready"}, 32'(s_arready), 32'd1);
        tick;
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && !m_arvalid && n < 20) begin
            tick;
            n++;
        end
        miss = m_arvalid;
        check({tag, " miss"}, 32'(miss), 32'(exp_miss));
        check({tag, " latency"}, 32'(n), 32'd1);
        if (miss) begin
            check({tag, " m_araddr"}, m_araddr, {addr[31:4], 4'h0});
            check({tag, " m_ar fields"}, {16'h0, m_arid, m_arlen, 2'b00, m_arsize, m_arburst},
                  {16'h0, 4'h0, 8'd3, 2'b00, 3'b010, 2'b01});
            m_arready = 1'b1;
            tick;
            m_arready = 1'b0;
            check({tag, " arvalid drop"}, 32'(m_arvalid), 32'd0);
            check({tag, " m_rready"}, 32'(m_rready), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (evt_kind == 2 && i == evt_beat) begin
                    m_rvalid = 1'b0;
                    reset = 1'b1;
                    #1;
                    check_reset_outputs({tag, " midreset"});
                    tick;
                    reset = 1'b0;
                    #1;
                    check({tag, " arready after release"}, 32'(s_arready), 32'd1);
                    return;
                end
                fence_i  = (evt_kind == 1 && i == evt_beat);
                m_rvalid = 1'b1;
                m_rdata  = words[i];
                m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
                m_rlast  = (i == 3);
                tick;
            end
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            m_rresp  = 2'b00;
            fence_i  = 1'b0;
            check({tag, " rready drop"}, 32'(m_rready), 32'd0);
        end
        check({tag, " s_rvalid"}, 32'(s_rvalid), 32'd1);
        check({tag, " s_rlast"},  32'(s_rlast),  32'd1);
        check({tag, " s_rdata"},  s_rdata,       exp_data);
        check({tag, " s_rresp"},  32'(s_rresp),  32'(exp_resp));
        for (int k = 0; k < hold; k++) begin
            s_arvalid = 1'b1;
            s_araddr  = addr ^ 32'h0000_0300;
            tick;
            check({tag, " hold rvalid"},  32'(s_rvalid),  32'd1);
            check({tag, " hold rdata"},   s_rdata,        exp_data);
            check({tag, " hold arready"}, 32'(s_arready), 32'd0);
        end
        s_arvalid = 1'b0;
        s_rready  = 1'b1;
        tick;
        s_rready  = 1'b0;
        check({tag, " rvalid drop"}, 32'(s_rvalid), 32'd0);
        if (evt_kind == 1) begin
            check({tag, " flush cycle arready"}, 32'(s_arready), 32'd0);
            tick;
            check({tag, " post flush arready"}, 32'(s_arready), 32'd1);
        end
    endtask

    initial begin
        tick;
        tick;
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        check("release arready", 32'(s_arready), 32'd1);

        fetch("cold", 32'h0F00_0000, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44,
              -1, 32'h11, 2'b00, 0, 0, 0);
        fetch("hit8", 32'h0F00_0008, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
              -1, 32'h33, 2'b00, 0, 0, 0);
        fetch("hold", 32'h0F00_0004, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
              -1, 32'h22, 2'b00, 5, 0, 0);
        fetch("conflict", 32'h0F00_0100, 1'b1, 32'h55, 32'h66, 32'h77, 32'h88,
              -1, 32'h55, 2'b00, 0, 0, 0);
        fetch("evicted", 32'h0F00_000C, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44,
              -1, 32'h44, 2'b00, 0, 0, 0);
        fetch("err", 32'h0F00_0020, 1'b1, 32'hB0, 32'hB1, 32'hB2, 32'hB3,
              2, 32'hB0, 2'b10, 0, 0, 0);
        fetch("err retry", 32'h0F00_0024, 1'b1, 32'hC0, 32'hC1, 32'hC2, 32'hC3,
              -1, 32'hC1, 2'b00, 0, 0, 0);
        fetch("err hit", 32'h0F00_0028, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
              -1, 32'hC2, 2'b00, 0, 0, 0);
        fetch("fence", 32'h0F00_0040, 1'b1, 32'hD0, 32'hD1, 32'hD2, 32'hD3,
              -1, 32'hD0, 2'b00, 0, 1, 1);
        fetch("post fence", 32'h0F00_0044, 1'b1, 32'hE0, 32'hE1, 32'hE2, 32'hE3,
              -1, 32'hE1, 2'b00, 0, 0, 0);
        fetch("old after fence", 32'h0F00_0008, 1'b1, 32'hF0, 32'hF1, 32'hF2, 32'hF3,
              -1, 32'hF2, 2'b00, 0, 0, 0);
        fetch("rst", 32'h0F00_0080, 1'b1, 32'h81, 32'h82, 32'h83, 32'h84,
              -1, 32'h81, 2'b00, 0, 2, 1);
        fetch("after rst", 32'h0F00_0080, 1'b1, 32'h91, 32'h92, 32'h93, 32'h94,
              -1, 32'h91, 2'b00, 0, 0, 0);
        fetch("rst cleared", 32'h0F00_0044, 1'b1, 32'hE0, 32'hE1, 32'hE2, 32'hE3,
              -1, 32'hE1, 2'b00, 0, 0, 0);
        fetch("rst refilled hit", 32'h0F00_0048, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
              -1, 32'hE2, 2'b00, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
